// File: rtl/off_buf_ctrl_pkg.sv
// Shared definitions for the offset-latch ping-pong sequencer: bank geometry,
// bank-base helper and the reader state encoding.
package off_buf_ctrl_pkg;

  localparam int DEF_NUM_WORDS = 64;
  localparam int DEF_HALF      = DEF_NUM_WORDS / 2;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_e;

  // Bank 0 starts at address 0, bank 1 at the midpoint of the latch array.
  function automatic int unsigned bank_base(input logic bank, input int unsigned half);
    return bank ? half : 32'd0;
  endfunction

endpackage

// File: rtl/off_bank_rd_seq.sv
// Reader sequencer: replays one bank as i_reps address sweeps, one address per
// cycle with i_rd_ready, and flags the final issue so the owner can release it.
module off_bank_rd_seq
  import off_buf_ctrl_pkg::*;
#(
  parameter int ADDR  = 6,
  parameter int REP_W = 4,
  parameter int HALF  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full_rb,
  input  logic             rb,
  input  logic [ADDR-1:0]  len_rb,
  input  logic [REP_W-1:0] i_reps,
  input  logic             i_rd_ready,
  output logic             issue,
  output logic             issue_last,
  output logic [ADDR-1:0]  rd_addr,
  output rd_state_e        state
);

  rd_state_e        state_n;
  logic [ADDR-1:0]  rd_ptr, rd_ptr_n, cur_ptr, rd_addr_q, base;
  logic [REP_W-1:0] rep_cnt, rep_n, cur_rep;
  logic             active, wrap;

  // In R_IDLE with the bank full, the drain-start values are used directly so
  // the first issue (and a back-to-back bank hand-over) costs no bubble.
  always_comb begin
    base       = ADDR'(bank_base(rb, HALF));
    cur_ptr    = (state == R_IDLE) ? '0 : rd_ptr;
    cur_rep    = (state == R_IDLE) ? ((i_reps == '0) ? REP_W'(1) : i_reps) : rep_cnt;
    active     = (state == R_RUN) || full_rb;
    issue      = active && i_rd_ready;
    wrap       = (cur_ptr == len_rb - ADDR'(1));
    issue_last = issue && wrap && (cur_rep == REP_W'(1));
    rd_addr    = issue ? (base + cur_ptr) : rd_addr_q;
    state_n    = state;
    rd_ptr_n   = rd_ptr;
    rep_n      = rep_cnt;
    if (active) begin
      state_n  = R_RUN;
      rd_ptr_n = cur_ptr;
      rep_n    = cur_rep;
      if (issue) begin
        if (wrap) begin
          rd_ptr_n = '0;
          if (cur_rep == REP_W'(1)) state_n = R_IDLE;
          else                      rep_n   = cur_rep - REP_W'(1);
        end else begin
          rd_ptr_n = cur_ptr + ADDR'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= R_IDLE;
      rd_ptr    <= '0;
      rep_cnt   <= '0;
      rd_addr_q <= '0;
    end else begin
      state   <= state_n;
      rd_ptr  <= rd_ptr_n;
      rep_cnt <= rep_n;
      if (issue) rd_addr_q <= rd_addr;
    end
  end

endmodule

// File: rtl/off_buf_ctrl.sv
// Ping-pong control for the offset latch buffer: the producer fills one bank
// while the reader sequencer replays the other; all controls replicate per lane.
module off_buf_ctrl
  import off_buf_ctrl_pkg::*;
#(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int ADDR      = 6,
  parameter int NUM_WORDS = 64,
  parameter int REP_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_valid,
  input  logic               i_wr_last,
  output logic               o_wr_ready,
  output logic [Tn-1:0]      o_wen,
  output logic [Tn*ADDR-1:0] o_wr_addr,
  input  logic [REP_W-1:0]   i_reps,
  input  logic               i_rd_ready,
  output logic [Tn*ADDR-1:0] o_rd_addr,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_busy
);

  localparam int HALF = NUM_WORDS / 2;

  logic                 wb, rb;
  logic [1:0]           full;
  logic [1:0][ADDR-1:0] len_q;
  logic [ADDR-1:0]      wr_ptr, wr_addr, rd_addr;
  logic                 accept, close, issue, issue_last;
  rd_state_e            rd_state;

  // Handshake: a word transfers on a cycle where i_wr_valid && o_wr_ready; the
  // producer may hold i_wr_valid across stalls and o_wr_ready only depends on state.
  assign o_wr_ready = !full[wb];
  assign accept     = i_wr_valid && o_wr_ready;
  assign close      = accept && (i_wr_last || (wr_ptr == ADDR'(HALF - 1)));
  assign wr_addr    = ADDR'(bank_base(wb, HALF)) + wr_ptr;
  assign o_busy     = (|full) || (rd_state == R_RUN);

  // N describes the data lane width only; the guard keeps it part of the build.
  if (N > 0) begin : g_lanes
    assign o_wen     = {Tn{accept}};
    assign o_wr_addr = {Tn{accept ? wr_addr : {ADDR{1'b0}}}};
    assign o_rd_addr = {Tn{rd_addr}};
  end else begin : g_no_lanes
    assign o_wen     = '0;
    assign o_wr_addr = '0;
    assign o_rd_addr = '0;
  end

  off_bank_rd_seq #(
    .ADDR (ADDR),
    .REP_W(REP_W),
    .HALF (HALF)
  ) u_rd_seq (
    .clk       (clk),
    .rst       (rst),
    .full_rb   (full[rb]),
    .rb        (rb),
    .len_rb    (len_q[rb]),
    .i_reps    (i_reps),
    .i_rd_ready(i_rd_ready),
    .issue     (issue),
    .issue_last(issue_last),
    .rd_addr   (rd_addr),
    .state     (rd_state)
  );

  // Close and release always target different banks, so both updates apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb         <= 1'b0;
      rb         <= 1'b0;
      full       <= '0;
      len_q      <= '0;
      wr_ptr     <= '0;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= close ? '0 : (wr_ptr + ADDR'(1));
      if (close) begin
        len_q[wb] <= wr_ptr + ADDR'(1);
        full[wb]  <= 1'b1;
        wb        <= ~wb;
      end
      if (issue_last) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      o_rd_valid <= issue;
      o_rd_last  <= issue_last;
    end
  end

endmodule

// File: tb/tb_off_buf_ctrl.sv
// Directed bench for off_buf_ctrl: stimulus pushes expected write/read addresses
// into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_off_buf_ctrl;

  localparam int N     = 16;
  localparam int TN    = 16;
  localparam int ADDR  = 6;
  localparam int NW    = 64;
  localparam int REP_W = 4;
  localparam int W     = ADDR + 1;

  logic               clk;
  logic               rst;
  logic               i_wr_valid;
  logic               i_wr_last;
  logic               o_wr_ready;
  logic [TN-1:0]      o_wen;
  logic [TN*ADDR-1:0] o_wr_addr;
  logic [REP_W-1:0]   i_reps;
  logic               i_rd_ready;
  logic [TN*ADDR-1:0] o_rd_addr;
  logic               o_rd_valid;
  logic               o_rd_last;
  logic               o_busy;

  logic [W-1:0]    wr_q[$];
  logic [W-1:0]    rd_q[$];
  logic [W-1:0]    mon_e;
  logic [ADDR-1:0] lat_addr;
  int              vectors;
  int              miscompares;

  off_buf_ctrl #(
    .N(N), .Tn(TN), .ADDR(ADDR), .NUM_WORDS(NW), .REP_W(REP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_wr_valid(i_wr_valid),
    .i_wr_last (i_wr_last),
    .o_wr_ready(o_wr_ready),
    .o_wen     (o_wen),
    .o_wr_addr (o_wr_addr),
    .i_reps    (i_reps),
    .i_rd_ready(i_rd_ready),
    .o_rd_addr (o_rd_addr),
    .o_rd_valid(o_rd_valid),
    .o_rd_last (o_rd_last),
    .o_busy    (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Models the latch's registered read address.
  always @(posedge clk) lat_addr <= o_rd_addr[ADDR-1:0];

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wen != '0) begin
        chk("wen_all_lanes", 64'(o_wen), 64'({TN{1'b1}}));
        chk("wr_addr_repl", 64'(o_wr_addr == {TN{o_wr_addr[ADDR-1:0]}}), 64'd1);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'(o_wr_addr[ADDR-1:0]), 64'hffff);
        end else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", 64'(o_wr_addr[ADDR-1:0]), 64'(mon_e[ADDR-1:0]));
        end
      end
      if (o_rd_valid) begin
        chk("rd_addr_repl", 64'(o_rd_addr == {TN{o_rd_addr[ADDR-1:0]}}), 64'd1);
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'({o_rd_last, lat_addr}), 64'hffff);
        end else begin
          mon_e = rd_q.pop_front();
          chk("rd_addr_last", 64'({o_rd_last, lat_addr}), 64'(mon_e));
        end
      end else if (o_rd_last) begin
        chk("rd_last_without_valid", 64'(o_rd_last), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic wr_word(input bit last, input logic [ADDR-1:0] a);
    int n;
    n = 0;
    wr_q.push_back({1'b0, a});
    i_wr_valid = 1'b1;
    i_wr_last  = last;
    @(negedge clk);
    while (!o_wr_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!o_wr_ready) chk("wr_ready_timeout", 64'(o_wr_ready), 64'd1);
    @(posedge clk);
    #1;
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic fill(input int base, input int len, input bit use_last);
    for (int i = 0; i < len; i++) wr_word(use_last && (i == len - 1), ADDR'(base + i));
  endtask

  task automatic push_reads(input int base, input int len, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < len; i++)
        rd_q.push_back({1'b0 | ((r == reps - 1) && (i == len - 1)), ADDR'(base + i)});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (rd_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("rd_drain_left", 64'(rd_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"},      64'(o_wen), 64'd0);
    chk({tag, "_wr_addr"},  64'(o_wr_addr == '0), 64'd1);
    chk({tag, "_rd_addr"},  64'(o_rd_addr == '0), 64'd1);
    chk({tag, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
    chk({tag, "_rd_last"},  64'(o_rd_last), 64'd0);
    chk({tag, "_wr_ready"}, 64'(o_wr_ready), 64'd1);
    chk({tag, "_busy"},     64'(o_busy), 64'd0);
  endtask

  logic [ADDR-1:0] held;
  bit              have_held;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    i_wr_valid  = 1'b0;
    i_wr_last   = 1'b0;
    i_reps      = 4'd1;
    i_rd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 5 words, two sweeps: 0..4,0..4 with last on the 10th valid
    i_reps     = 4'd2;
    i_rd_ready = 1'b1;
    push_reads(0, 5, 2);
    fill(0, 5, 1);
    wait_drain(200);
    chk("busy_after_t1", 64'(o_busy), 64'd0);

    // i_reps=0 with one word in bank 1: single read of address 32 with last
    i_reps = 4'd0;
    push_reads(32, 1, 1);
    fill(32, 1, 1);
    wait_drain(200);

    // 32 words, no last: auto-close at 31
    i_reps = 4'd1;
    push_reads(0, 32, 1);
    fill(0, 32, 0);
    wait_drain(300);

    // bank 1 next at 32; read ready toggles every other cycle
    i_rd_ready = 1'b0;
    push_reads(32, 4, 1);
    fill(32, 4, 1);
    have_held = 1'b0;
    for (int c = 0; c < 16; c++) begin
      i_rd_ready = (c % 2 == 0);
      @(negedge clk);
      if (i_rd_ready) begin
        held      = o_rd_addr[ADDR-1:0];
        have_held = 1'b1;
      end else if (have_held) begin
        chk("rd_addr_hold", 64'(o_rd_addr), 64'({TN{held}}));
      end
      @(posedge clk);
      #1;
    end
    i_rd_ready = 1'b1;
    wait_drain(200);

    // both banks filled with the reader stalled
    i_rd_ready = 1'b0;
    push_reads(0, 3, 1);
    push_reads(32, 2, 1);
    fill(0, 3, 1);
    fill(32, 2, 1);
    @(negedge clk);
    chk("stall_wr_ready", 64'(o_wr_ready), 64'd0);
    chk("stall_busy", 64'(o_busy), 64'd1);
    chk("stall_no_valid", 64'(o_rd_valid), 64'd0);
    @(posedge clk);
    #1;
    i_rd_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("pp_wr_ready_c%0d", c), 64'(o_wr_ready), 64'(c >= 3));
      chk($sformatf("pp_rd_valid_c%0d", c), 64'(o_rd_valid), 64'((c >= 1) && (c <= 5)));
      @(posedge clk);
      #1;
    end
    wait_drain(200);

    // reset in the middle of a drain of bank 1
    i_reps = 4'd1;
    push_reads(0, 1, 1);
    fill(0, 1, 1);
    wait_drain(200);
    i_reps = 4'd3;
    push_reads(32, 8, 3);
    fill(32, 8, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    rd_q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    i_reps = 4'd1;
    push_reads(0, 1, 1);
    fill(0, 1, 1);
    wait_drain(200);
    chk("wr_queue_left", 64'(wr_q.size()), 64'd0);
    chk("final_busy", 64'(o_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
